// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and widths for the fetch stage of the 8-bit core.
package instr_fetch_unit_pkg;

  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned INSTR_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    HALT
  } fetch_state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } ifq_entry_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/response bus plus the decode-facing instruction queue port.
interface instr_fetch_unit_if
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned IFQ_DEPTH = 4
);

  logic                           imem_req;
  logic [ADDR_W-1:0]              imem_addr;
  logic                           imem_gnt;
  logic                           imem_rvalid;
  logic [INSTR_W-1:0]             imem_rdata;
  logic                           ifq_valid;
  logic [INSTR_W-1:0]             ifq_instr;
  logic [ADDR_W-1:0]              ifq_pc;
  logic                           ifq_ready;
  logic [$clog2(IFQ_DEPTH+1)-1:0] ifq_count;

  // Fetch unit side.
  modport master (
    output imem_req, imem_addr, ifq_valid, ifq_instr, ifq_pc, ifq_count,
    input  imem_gnt, imem_rvalid, imem_rdata, ifq_ready
  );

  // Memory / decode side.
  modport slave (
    input  imem_req, imem_addr, ifq_valid, ifq_instr, ifq_pc, ifq_count,
    output imem_gnt, imem_rvalid, imem_rdata, ifq_ready
  );

endinterface

// File: rtl/instr_fetch_unit_ifq.sv
// Instruction queue: small synchronous FIFO of {instr, pc} entries with a flush clear.
module fetch_ifq
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  ifq_entry_t       din_i,
  input  logic             pop_i,
  input  logic             clear_i,
  output logic             valid_o,
  output ifq_entry_t       head_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  ifq_entry_t       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q;
  logic [PTR_W-1:0] rd_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (clear_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + PTR_W'(1);
      if (pop_i)  rd_q <= rd_q + PTR_W'(1);
      case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (push_i && !clear_i) mem_q[wr_q] <= din_i;
  end

  assign valid_o = (cnt_q != '0);
  assign head_o  = valid_o ? mem_q[rd_q] : '0;
  assign count_o = cnt_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues one-outstanding imem requests, queues returned instructions.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned IFQ_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  start_addr,
  input  logic [ADDR_W-1:0]  next_pc,
  output logic [ADDR_W-1:0]  cur_pc,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  flush_pc,
  input  logic               halt,
  output logic               halted,
  instr_fetch_unit_if.master bus
);

  localparam int unsigned CNT_W = $clog2(IFQ_DEPTH+1);

  fetch_state_t      state_q;
  logic [ADDR_W-1:0] cur_pc_q;
  logic [ADDR_W-1:0] issue_pc_q;
  logic              discard_q;
  logic              halt_pend_q;
  logic              halted_q;

  logic              req;
  logic              grant;
  logic              push;
  logic              pop;
  logic              q_valid;
  ifq_entry_t        q_head;
  ifq_entry_t        q_din;
  logic [CNT_W-1:0]  q_count;

  assign req   = (state_q == REQ) && (q_count < CNT_W'(IFQ_DEPTH));
  assign grant = req && bus.imem_gnt;

  // Flush empties the queue on the same edge, so it masks any concurrent push or pop.
  assign push  = (state_q == WAIT) && bus.imem_rvalid && !discard_q && !flush;
  assign pop   = q_valid && bus.ifq_ready && !flush;

  assign q_din.instr = bus.imem_rdata;
  assign q_din.pc    = issue_pc_q;

  fetch_ifq #(
    .DEPTH (IFQ_DEPTH)
  ) u_ifq (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .din_i   (q_din),
    .pop_i   (pop),
    .clear_i (flush),
    .valid_o (q_valid),
    .head_o  (q_head),
    .count_o (q_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cur_pc_q    <= start_addr;
      issue_pc_q  <= '0;
      discard_q   <= 1'b0;
      halt_pend_q <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      if (halt)  halt_pend_q <= 1'b1;
      if (flush) cur_pc_q    <= flush_pc;

      case (state_q)
        IDLE: state_q <= REQ;
        REQ: begin
          if (grant) begin
            issue_pc_q <= cur_pc_q;
            // A flushed grant stays outstanding; its response is dropped on arrival.
            if (flush) discard_q <= 1'b1;
            else       cur_pc_q  <= next_pc;
            state_q <= WAIT;
          end else if (halt || halt_pend_q) begin
            state_q  <= HALT;
            halted_q <= 1'b1;
          end
        end
        WAIT: begin
          if (bus.imem_rvalid) begin
            discard_q <= 1'b0;
            if (halt || halt_pend_q) begin
              state_q  <= HALT;
              halted_q <= 1'b1;
            end else begin
              state_q <= REQ;
            end
          end else if (flush) begin
            discard_q <= 1'b1;
          end
        end
        HALT:    state_q <= HALT;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cur_pc        = cur_pc_q;
  assign halted        = halted_q;
  assign bus.imem_req  = req;
  assign bus.imem_addr = cur_pc_q;
  assign bus.ifq_valid = q_valid;
  assign bus.ifq_instr = q_head.instr;
  assign bus.ifq_pc    = q_head.pc;
  assign bus.ifq_count = q_count;

endmodule
